can_rx_buffer: RTL and testbench

Receive-side message buffer for the CAN controller, the counterpart of the transmit priority queue.
- Accepts fully decoded frames from the bit-level RX engine.
- Applies an 11-bit acceptance code/mask filter.
- Stores accepted frames in an N-entry FIFO (arrival order) that the host drains with a read strobe.
- Reports full, empty, occupancy and a sticky overrun flag.

---
 rtl/can_pkg.sv | 20 ++
 rtl/can_acc_filter.sv | 14 +
 rtl/can_rx_buffer.sv | 121 ++++++++++++
 tb/tb_can_rx_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, the frame record used by the TX and RX blocks,
// and the DLC-to-byte-count helper.
package can_pkg;

  localparam int CAN_ID_W      = 11;
  localparam int CAN_DLC_W     = 4;
  localparam int CAN_MAX_BYTES = 8;

  typedef struct packed {
    logic [CAN_ID_W-1:0]                id;
    logic [CAN_DLC_W-1:0]               dlc;
    logic [CAN_MAX_BYTES-1:0][7:0]      data;
  } can_frame_t;

  // Classic CAN: DLC codes 9..15 still carry eight payload bytes.
  function automatic logic [CAN_DLC_W-1:0] dlc_to_len(input logic [CAN_DLC_W-1:0] dlc);
    return (dlc > CAN_DLC_W'(CAN_MAX_BYTES)) ? CAN_DLC_W'(CAN_MAX_BYTES) : dlc;
  endfunction

endpackage

// File: rtl/can_acc_filter.sv
// Single acceptance filter: an identifier passes when every bit not masked out
// (mask bit = 0) matches the acceptance code.
module can_acc_filter
  import can_pkg::*;
(
  input  logic [CAN_ID_W-1:0] id,
  input  logic [CAN_ID_W-1:0] code,
  input  logic [CAN_ID_W-1:0] mask,
  output logic                accept
);

  assign accept = (((id ^ code) & ~mask) == '0);

endmodule

// File: rtl/can_rx_buffer.sv
// Receive frame FIFO with acceptance filtering, show-ahead head output and sticky overrun.
// Optional per-entry capture timestamps are enabled by defining CAN_RX_TIMESTAMP_EN.
module can_rx_buffer
  import can_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic [CAN_ID_W-1:0]  rx_id,
  input  logic [CAN_DLC_W-1:0] rx_dlc,
  input  logic [7:0]           rx_data [CAN_MAX_BYTES],
  input  logic [CAN_ID_W-1:0]  acc_code,
  input  logic [CAN_ID_W-1:0]  acc_mask,
  input  logic                 re,
  input  logic                 ovr_clr,
  output logic                 out_valid,
  output logic [CAN_ID_W-1:0]  out_id,
  output logic [CAN_DLC_W-1:0] out_dlc,
  output logic [7:0]           out_data [CAN_MAX_BYTES],
  output logic                 full,
  output logic                 empty,
  output logic [CW-1:0]        count,
`ifdef CAN_RX_TIMESTAMP_EN
  output logic [15:0]          out_ts,
`endif
  output logic                 overrun
);

  localparam int PW = $clog2(N);

  can_frame_t          mem [N];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       cnt;
  logic                id_match;
  logic                accept;
  logic                do_pop;
  logic                do_push;
  logic                drop;
  logic [CAN_DLC_W-1:0] len;
  can_frame_t          wr_frame;
  can_frame_t          head;

`ifdef CAN_RX_TIMESTAMP_EN
  logic [15:0]         ts_mem [N];
  logic [15:0]         ts_cnt;
`endif

  can_acc_filter u_filter (
    .id     (rx_id),
    .code   (acc_code),
    .mask   (acc_mask),
    .accept (id_match)
  );

  assign accept  = rx_valid & id_match;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(N));
  assign count   = cnt;
  assign do_pop  = re & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
  assign do_push = accept & (~full | do_pop);
  assign drop    = accept & full & ~re;
  assign len     = dlc_to_len(rx_dlc);

  always_comb begin
    wr_frame     = '0;
    wr_frame.id  = rx_id;
    wr_frame.dlc = rx_dlc;
    for (int i = 0; i < CAN_MAX_BYTES; i++) begin
      if (i < int'(len)) wr_frame.data[i] = rx_data[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  // Storage carries no reset; the pointers and count alone define valid content.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_frame;
`ifdef CAN_RX_TIMESTAMP_EN
      ts_mem[wr_ptr] <= ts_cnt;
`endif
    end
  end

`ifdef CAN_RX_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 16'd1;
  end

  assign out_ts = empty ? '0 : ts_mem[rd_ptr];
`endif

  assign head      = mem[rd_ptr];
  assign out_valid = ~empty;
  assign out_id    = empty ? '0 : head.id;
  assign out_dlc   = empty ? '0 : head.dlc;

  for (genvar gi = 0; gi < CAN_MAX_BYTES; gi++) begin : g_out_data
    assign out_data[gi] = empty ? '0 : head.data[gi];
  end

endmodule

// File: tb/tb_can_rx_buffer.sv
// Scoreboard bench for can_rx_buffer: a queue-level FIFO model predicts contents and flags,
// a negedge monitor checks status every cycle and each popped head frame.
module tb_can_rx_buffer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic [10:0] rx_id = '0;
  logic [3:0]  rx_dlc = '0;
  logic [7:0]  rx_data [8];
  logic [10:0] acc_code = '0;
  logic [10:0] acc_mask = 11'h7FF;
  logic        re = 1'b0;
  logic        ovr_clr = 1'b0;
  logic        out_valid;
  logic [10:0] out_id;
  logic [3:0]  out_dlc;
  logic [7:0]  out_data [8];
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overrun;
`ifdef CAN_RX_TIMESTAMP_EN
  logic [15:0] out_ts;
`endif

  always #5 clk = ~clk;

  can_rx_buffer #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_id     (rx_id),
    .rx_dlc    (rx_dlc),
    .rx_data   (rx_data),
    .acc_code  (acc_code),
    .acc_mask  (acc_mask),
    .re        (re),
    .ovr_clr   (ovr_clr),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_dlc   (out_dlc),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
`ifdef CAN_RX_TIMESTAMP_EN
    .out_ts    (out_ts),
`endif
    .overrun   (overrun)
  );

  typedef struct {
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } tf_t;

  tf_t fifo_q[$];   // model FIFO contents after the coming edge
  tf_t chk_q[$];    // frames the DUT is expected to hand out, in order
  bit  m_ovr = 0;
  int  exp_count = 0;
  bit  exp_ovr = 0;
  bit  started = 0;
  bit  in_reset = 1;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[8*i +: 8] = out_data[i];
    return p;
  endfunction

  // Drive one cycle of stimulus and advance the model to the state after the next edge.
  task automatic step(input bit v, input logic [10:0] id, input logic [3:0] dlc,
                      input logic [63:0] bytes, input bit r, input bit clr);
    tf_t f;
    bit  acc;
    bit  dropped;
    int  len;
    rx_valid = v;
    rx_id    = id;
    rx_dlc   = dlc;
    for (int i = 0; i < 8; i++) rx_data[i] = bytes[8*i +: 8];
    re       = r;
    ovr_clr  = clr;
    exp_count = fifo_q.size();
    exp_ovr   = m_ovr;
    dropped   = 0;
    if (r && fifo_q.size() > 0) chk_q.push_back(fifo_q.pop_front());
    acc = v && ((id & ~acc_mask) == (acc_code & ~acc_mask));
    if (acc) begin
      if (fifo_q.size() < N) begin
        len    = (dlc > 8) ? 8 : int'(dlc);
        f.id   = id;
        f.dlc  = dlc;
        f.data = '0;
        for (int i = 0; i < len; i++) f.data[8*i +: 8] = bytes[8*i +: 8];
        fifo_q.push_back(f);
      end else begin
        dropped = 1;
      end
    end
    if (dropped) m_ovr = 1;
    else if (clr) m_ovr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, '0, '0, '0, 0, 0);
  endtask

  task automatic pop();
    step(0, '0, '0, '0, 1, 0);
  endtask

  always @(negedge clk) begin
    tf_t e;
    if (started && !in_reset) begin
      check("count", 64'(count), 64'(exp_count));
      check("full", 64'(full), 64'(exp_count == N));
      check("empty", 64'(empty), 64'(exp_count == 0));
      check("out_valid", 64'(out_valid), 64'(exp_count != 0));
      check("overrun", 64'(overrun), 64'(exp_ovr));
      if (exp_count == 0) begin
        check("idle_id", 64'(out_id), 64'd0);
        check("idle_data", pack_out(), 64'd0);
      end
      if (re && out_valid) begin
        if (chk_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop: DUT popped id %0h but no entry expected", out_id);
        end else begin
          e = chk_q.pop_front();
          check("pop_id", 64'(out_id), 64'(e.id));
          check("pop_dlc", 64'(out_dlc), 64'(e.dlc));
          check("pop_data", pack_out(), e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] t1;
    logic [15:0] t2;
    logic [10:0] ids [4];
    bit          rv;
    bit          rr;
    bit          rc;
    for (int i = 0; i < 8; i++) rx_data[i] = '0;
    t1 = '0;
    t2 = '0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    check("rst_id", 64'(out_id), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_reset = 0;
    started  = 1;

    // Ordered fill to full and drain
    ids[0] = 11'h300; ids[1] = 11'h200; ids[2] = 11'h100; ids[3] = 11'h400;
    for (int i = 0; i < 4; i++) step(1, ids[i], 4'd8, {8{8'(i)}}, 0, 0);
    repeat (4) pop();
    idle();

    // Acceptance filter
    acc_code = 11'h120;
    acc_mask = 11'h00F;
    step(1, 11'h123, 4'd2, 64'hA1A2, 0, 0);
    step(1, 11'h130, 4'd2, 64'hB1B2, 0, 0);
    step(1, 11'h12F, 4'd2, 64'hC1C2, 0, 0);
    idle();
    repeat (2) pop();
    acc_mask = 11'h7FF;

    // Overrun, then clear; then simultaneous write and pop while full
    for (int i = 0; i < 4; i++) step(1, 11'(16 + i), 4'd1, 64'(i + 1), 0, 0);
    step(1, 11'h555, 4'd1, 64'h55, 0, 0);
    idle();
    step(0, '0, '0, '0, 0, 1);
    idle();
    step(1, 11'h666, 4'd4, 64'h6666_6666, 1, 0);
    repeat (4) pop();

    // Payload zeroing by DLC
    step(1, 11'h050, 4'd3, 64'h8877_6655_4433_2211, 0, 0);
    step(1, 11'h051, 4'd12, 64'h8877_6655_4433_2211, 0, 0);
    repeat (2) pop();

    // Asynchronous reset with two entries and overrun set
    for (int i = 0; i < 5; i++) step(1, 11'(32 + i), 4'd2, 64'h77, 0, 0);
    repeat (2) pop();
    idle();
    rx_valid = 0; re = 0; ovr_clr = 0;
    #1 rst_n = 1'b0;
    in_reset = 1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_ovr", 64'(overrun), 64'd0);
    fifo_q.delete();
    chk_q.delete();
    m_ovr = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_reset = 0;

    // Randomized traffic with occasional filter changes
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        acc_code = 11'($urandom_range(0, 2047));
        case ($urandom_range(0, 2))
          0:       acc_mask = 11'h7FF;
          1:       acc_mask = 11'h00F;
          default: acc_mask = 11'($urandom_range(0, 2047));
        endcase
      end
      rv = ($urandom_range(0, 99) < 60);
      rr = ($urandom_range(0, 99) < 40);
      rc = ($urandom_range(0, 99) < 5);
      step(rv, 11'($urandom_range(0, 2047)), 4'($urandom_range(0, 15)),
           {32'($urandom), 32'($urandom)}, rr, rc);
    end
    acc_mask = 11'h7FF;
    repeat (N + 1) pop();
    step(0, '0, '0, '0, 0, 1);
    idle();

`ifdef CAN_RX_TIMESTAMP_EN
    step(1, 11'h0A0, 4'd1, 64'h1, 0, 0);
    t1 = out_ts;
    repeat (4) idle();
    step(1, 11'h0A1, 4'd1, 64'h2, 0, 0);
    pop();
    t2 = out_ts;
    check("ts_delta", 64'(16'(t2 - t1)), 64'd5);
    pop();
    idle();
`endif

    check("leftover", 64'(chk_q.size()), 64'd0);
    started = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
